// File: rtl/vector_sweeper_if.sv
// vector_sweeper_if
//   Groups the handshake and stimulus/response signals of vector_sweeper.
//   master : the sequencer's controller and the downstream logic stage
//            (drives start, abort and outa; observes the stimulus and status)
//   slave  : vector_sweeper itself
//   Signals:
//     start, abort       sweep control
//     outa               response of the downstream stage
//     va, vb, vc, vd     4-bit stimulus vector (va = bit 3, vd = bit 0)
//     busy, done         sweep status (done is a one-cycle pulse)
//     result[15:0]       captured response, bit i = response to vector i
//     mismatch           result differs from the golden response
interface vector_sweeper_if;
   logic        start;
   logic        abort;
   logic        outa;
   logic        va;
   logic        vb;
   logic        vc;
   logic        vd;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        mismatch;

   modport master (
      output start, abort, outa,
      input  va, vb, vc, vd, busy, done, result, mismatch
   );

   modport slave (
      input  start, abort, outa,
      output va, vb, vc, vd, busy, done, result, mismatch
   );
endinterface

// File: rtl/vector_sweeper.sv
// vector_sweeper
//   Steps a 4-bit stimulus vector 0..15 onto va..vd, holds each vector for
//   HOLD_CYCLES cycles and captures the downstream response outa on the
//   last hold cycle of each vector into result[vector].
//   Parameters:
//     HOLD_CYCLES  cycles per vector (1..255)
//     EXPECTED     golden 16-bit response, only used with the checker enabled
//   Ports:
//     clk          sole clock, rising edge
//     rst          synchronous active-high reset
//     sw           vector_sweeper_if.slave (start/abort/outa in,
//                  va..vd/busy/done/result/mismatch out; all registered)
//   Optional feature:
//     VECTOR_SWEEPER_CHECK_EN  when defined, mismatch is set on the
//     DONE->IDLE edge if result != EXPECTED and stays until the next accepted
//     start or reset. When undefined, mismatch is tied low.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start (abort low); outputs quiet, result held
//   DRIVE  | driving vector, counting hold cycles, capturing outa
//   DONE   | one-cycle completion pulse, then back to IDLE
module vector_sweeper #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter logic [15:0] EXPECTED    = 16'h0000
) (
   input logic             clk,
   input logic             rst,
   vector_sweeper_if.slave sw
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  vec_q, vec_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  drv_q, drv_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] result_q, result_d;

`ifdef VECTOR_SWEEPER_CHECK_EN
   logic        mismatch_q, mismatch_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         vec_q    <= 4'd0;
         cnt_q    <= 8'd0;
         drv_q    <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 16'h0000;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         cnt_q    <= cnt_d;
         drv_q    <= drv_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

`ifdef VECTOR_SWEEPER_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= mismatch_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      cnt_d    = cnt_q;
      result_d = result_q;
`ifdef VECTOR_SWEEPER_CHECK_EN
      mismatch_d = mismatch_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (sw.start && !sw.abort) begin
               state_d  = ST_DRIVE;
               vec_d    = 4'd0;
               cnt_d    = 8'd0;
               result_d = 16'h0000;
`ifdef VECTOR_SWEEPER_CHECK_EN
               mismatch_d = 1'b0;
`endif
            end
         end

         ST_DRIVE: begin
            // abort beats the capture scheduled for this same edge
            if (sw.abort) begin
               state_d = ST_IDLE;
               vec_d   = 4'd0;
               cnt_d   = 8'd0;
            end else if (cnt_q == LAST_CNT) begin
               result_d[vec_q] = sw.outa;
               cnt_d           = 8'd0;
               if (vec_q == 4'hF) begin
                  state_d = ST_DONE;
                  vec_d   = 4'd0;
               end else begin
                  vec_d = vec_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
`ifdef VECTOR_SWEEPER_CHECK_EN
            mismatch_d = (result_q != EXPECTED);
`endif
         end

         default: begin
            state_d = ST_IDLE;
            vec_d   = 4'd0;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Output flops are loaded from the next state so they line up with it.
   always_comb begin
      busy_d = (state_d == ST_DRIVE);
      done_d = (state_d == ST_DONE);
      drv_d  = busy_d ? vec_d : 4'd0;
   end

   assign sw.va     = drv_q[3];
   assign sw.vb     = drv_q[2];
   assign sw.vc     = drv_q[1];
   assign sw.vd     = drv_q[0];
   assign sw.busy   = busy_q;
   assign sw.done   = done_q;
   assign sw.result = result_q;

`ifdef VECTOR_SWEEPER_CHECK_EN
   assign sw.mismatch = mismatch_q;
`else
   // Golden value has no consumer without the checker.
   logic [15:0] unused_expected;
   assign unused_expected = EXPECTED;
   assign sw.mismatch     = 1'b0;
`endif

endmodule

// File: doc/vector_sweeper.md
VECTOR_SWEEPER -- requirements
Module: vector_sweeper

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles each input vector is held (legal 1..255).
REQ-002 Parameter EXPECTED, default 16'h0000: golden 16-bit response, bit i for vector i. Used only under REQ-027.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin sweep; accepted only in IDLE.
REQ-006 abort  input  1  terminate sweep.
REQ-007 outa  input  1  response from the downstream logic stage, sampled per vector.
REQ-008 va  output  1  stimulus, vector bit 3.
REQ-009 vb  output  1  stimulus, vector bit 2.
REQ-010 vc  output  1  stimulus, vector bit 1.
REQ-011 vd  output  1  stimulus, vector bit 0.
REQ-012 busy  output  1  high while in DRIVE.
REQ-013 done  output  1  one-cycle pulse at sweep completion.
REQ-014 result  output  16  captured outa per vector; bit i = response to vector i.
REQ-015 mismatch  output  1  result differs from EXPECTED (REQ-027).

Function
REQ-016 States: IDLE, DRIVE, DONE; all outputs registered.
- IDLE -> DRIVE: start=1 and abort=0.
- DRIVE -> DONE: last vector sampled.
- DRIVE -> IDLE: abort=1.
- DONE -> IDLE: unconditional after one cycle.
REQ-017 Start acceptance:
- result cleared to 0.
- mismatch cleared to 0.
- Next cycle: state DRIVE, vector=0, hold counter=0, busy=1.
REQ-018 DRIVE vector hold:
- {va,vb,vc,vd} = current 4-bit vector index.
- Hold counter increments each cycle.
- Each vector is driven for exactly HOLD_CYCLES consecutive cycles.
REQ-019 Final hold cycle (counter = HOLD_CYCLES-1):
- result[vector] <= outa at that edge.
- Then vector+1 and counter=0, or DONE if vector=15.
REQ-020 Timing:
- busy is high for exactly 16*HOLD_CYCLES cycles per sweep.
- done=1 in the cycle immediately following the last busy cycle.
- HOLD_CYCLES=1: new vector every cycle; outa sampled in the same cycle the vector is driven.
REQ-021 Outside DRIVE: va..vd=0 and busy=0.
- result holds its value until the next accepted start.
REQ-022 start is ignored in DRIVE and DONE; no queuing.
REQ-023 abort behaviour:
- abort in DRIVE wins over the sample at that edge: no capture, IDLE next cycle, done never pulses.
- result keeps bits already captured.
- abort in IDLE or DONE has no effect.
- abort=1 together with start=1 in IDLE: sweep not started.
REQ-024 Vector counter is 4 bits and never wraps; 15 is always terminal.

Reset
REQ-025 rst=1 at a rising edge, in any state including mid-sweep:
- state=IDLE, vector=0, hold counter=0.
- va=vb=vc=vd=0, busy=0, done=0, result=16'h0000, mismatch=0.
REQ-026 rst has priority over start and abort.

Configuration
REQ-027 Macro VECTOR_SWEEPER_CHECK_EN.
- Defined: on the DONE->IDLE edge, mismatch <= (result != EXPECTED). mismatch stays sticky until the next accepted start or rst.
- Not defined: mismatch is constant 0, no comparator logic exists, EXPECTED is unused.

Verification
REQ-028 Full sweep, HOLD_CYCLES=2, outa tied 1, start pulse -> busy high 32 cycles, done pulse next cycle, result=16'hFFFF.
REQ-029 Bench model outa = ~(va&vd), HOLD_CYCLES=1 -> result=16'h55FF, done 17 cycles after start is sampled.
REQ-030 abort asserted while vector=5, HOLD_CYCLES=4 -> next cycle busy=0, va..vd=0; no done; result bits 5..15 remain 0.
REQ-031 rst asserted mid-sweep at vector 9 -> next cycle all outputs 0; start one cycle later restarts at vector 0.
REQ-032 start held high throughout a sweep -> exactly one sweep before done; a new sweep begins only once start is sampled in IDLE after DONE.
REQ-033 Macro defined, model as REQ-029: EXPECTED=16'h55FF -> mismatch=0; EXPECTED=16'h55FE -> mismatch=1 from the cycle after done; macro undefined -> mismatch always 0.
